// File: rtl/bits_seq.sv
// Byte-to-nibble sequencer: launches the BITS core, streams packet bytes from
// memory as high/low nibbles, then waits for core_done with a timeout.
module bits_seq #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int AW             = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [15:0]   expected_bytes,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_rvalid,
    input  logic [7:0]    mem_rdata,
    output logic          core_start,
    output logic          nib_valid,
    output logic [3:0]    nib_data,
    input  logic          nib_ready,
    input  logic          core_done,
    output logic          busy,
    output logic          seq_done,
    output logic [1:0]    seq_err,
    output logic [2:0]    fsm_state
);

    // Nibble stream handshake: a nibble transfers on a rising edge where
    // nib_valid and nib_ready are both 1; nib_valid/nib_data hold until then.

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        FETCH     = 3'd2,
        WAIT_DATA = 3'd3,
        SEND_HI   = 3'd4,
        SEND_LO   = 3'd5,
        WAIT_DONE = 3'd6,
        FINISH    = 3'd7
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [AW-1:0] addr;
    logic [15:0]   remaining;
    logic [TW-1:0] tcnt;
    logic [7:0]    byte_q;

    assign mem_addr  = addr;
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr       <= '0;
            remaining  <= '0;
            tcnt       <= '0;
            byte_q     <= '0;
            busy       <= 1'b0;
            seq_done   <= 1'b0;
            core_start <= 1'b0;
            mem_rd     <= 1'b0;
            nib_valid  <= 1'b0;
            nib_data   <= 4'd0;
            seq_err    <= 2'd0;
        end else begin
            core_start <= 1'b0;
            mem_rd     <= 1'b0;
            seq_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (expected_bytes != 16'd0) begin
                            remaining  <= expected_bytes;
                            addr       <= '0;
                            seq_err    <= 2'd0;
                            core_start <= 1'b1;
                            state      <= LAUNCH;
                        end else begin
                            seq_err <= 2'd1;
                            state   <= FINISH;
                        end
                    end
                end
                LAUNCH: begin
                    mem_rd <= 1'b1;
                    state  <= FETCH;
                end
                FETCH: begin
                    if (core_done) begin
                        seq_err <= 2'd2;
                        state   <= FINISH;
                    end else begin
                        state <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (core_done) begin
                        seq_err <= 2'd2;
                        state   <= FINISH;
                    end else if (mem_rvalid) begin
                        byte_q    <= mem_rdata;
                        nib_valid <= 1'b1;
                        nib_data  <= mem_rdata[7:4];
                        state     <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (core_done) begin
                        seq_err   <= 2'd2;
                        nib_valid <= 1'b0;
                        nib_data  <= 4'd0;
                        state     <= FINISH;
                    end else if (nib_ready) begin
                        nib_data <= byte_q[3:0];
                        state    <= SEND_LO;
                    end else begin
                        nib_data <= byte_q[7:4];
                    end
                end
                SEND_LO: begin
                    if (core_done) begin
                        seq_err   <= 2'd2;
                        nib_valid <= 1'b0;
                        nib_data  <= 4'd0;
                        state     <= FINISH;
                    end else if (nib_ready) begin
                        addr      <= addr + AW'(1);
                        remaining <= remaining - 16'd1;
                        nib_valid <= 1'b0;
                        nib_data  <= 4'd0;
                        tcnt      <= '0;
                        if (remaining > 16'd1) begin
                            mem_rd <= 1'b1;
                            state  <= FETCH;
                        end else begin
                            state <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    // core_done wins over a timeout landing in the same cycle
                    if (core_done) begin
                        seq_err <= 2'd0;
                        state   <= FINISH;
                    end else if (tcnt == T_LAST) begin
                        seq_err <= 2'd3;
                        state   <= FINISH;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                FINISH: begin
                    seq_done <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bits_seq.sv
// Directed bench for bits_seq: memory responder, nibble sink and one task per
// scenario, each checking its own hand-computed expectations.
`timescale 1ns/1ps
module tb_bits_seq;

    localparam int AW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset, start, mem_rvalid, nib_ready, core_done;
    logic [15:0]   expected_bytes;
    logic          mem_rd, core_start, nib_valid, busy, seq_done;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic [3:0]    nib_data;
    logic [1:0]    seq_err;
    logic [2:0]    fsm_state;

    int checks = 0;
    int fails  = 0;

    logic [7:0]    mem [16];
    int            rd_lat = 1;
    int            ready_mode = 0;
    logic [3:0]    nib_log[$];
    logic [AW-1:0] rd_log[$];
    logic [3:0]    exp_q[$];
    logic [AW-1:0] exp_a[$];
    int            cs_cnt = 0, done_cnt = 0, stall_viol = 0, stalls = 0;
    int            cyc = 0, last_nib_cyc = 0, done_cyc = 0;
    logic [1:0]    last_err = 2'd0;

    bits_seq #(.TIMEOUT_CYCLES(TO), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .expected_bytes(expected_bytes),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .core_start(core_start), .nib_valid(nib_valid), .nib_data(nib_data),
        .nib_ready(nib_ready), .core_done(core_done), .busy(busy), .seq_done(seq_done),
        .seq_err(seq_err), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Memory responder: answers each mem_rd rd_lat cycles later with one rvalid beat.
    initial begin
        logic [AW-1:0] pend;
        int cd;
        cd = 0;
        pend = '0;
        mem_rvalid = 1'b0;
        mem_rdata = 8'd0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = mem[pend];
                end
            end
            if (mem_rd === 1'b1) begin
                pend = mem_addr;
                rd_log.push_back(mem_addr);
                cd = rd_lat;
            end
        end
    end

    // Nibble sink and event recorder.
    initial begin
        logic was_stalled;
        logic [3:0] held;
        was_stalled = 1'b0;
        held = 4'd0;
        nib_ready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            nib_ready = (ready_mode == 1) ? ~nib_ready : 1'b1;
            if (was_stalled && (nib_valid !== 1'b1 || nib_data !== held)) stall_viol++;
            if (nib_valid === 1'b1 && nib_ready === 1'b1) begin
                nib_log.push_back(nib_data);
                last_nib_cyc = cyc;
            end
            was_stalled = (nib_valid === 1'b1 && nib_ready !== 1'b1);
            if (was_stalled) stalls++;
            held = nib_data;
            if (core_start === 1'b1) cs_cnt++;
            if (seq_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                last_err = seq_err;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        nib_log.delete();
        rd_log.delete();
        exp_q.delete();
        exp_a.delete();
    endtask

    task automatic launch(input logic [15:0] n);
        expected_bytes = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        expected_bytes = 16'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        core_done = 1'b0;
        expected_bytes = 16'd0;
        repeat (3) tick();
        checks++;
        if ({busy, seq_done, core_start, mem_rd, nib_valid, mem_addr, nib_data, seq_err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b done=%b cs=%b rd=%b nv=%b addr=%h nd=%h err=%0d, want all 0",
                     busy, seq_done, core_start, mem_rd, nib_valid, mem_addr, nib_data, seq_err);
        end
        checks++;
        if (fsm_state !== 3'd0) begin
            fails++;
            $display("FAIL reset_state: got %0d want 0", fsm_state);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        int base_cs, base_done;
        clear_logs();
        mem[0] = 8'h8A;
        mem[1] = 8'h00;
        rd_lat = 1;
        ready_mode = 0;
        base_cs = cs_cnt;
        base_done = done_cnt;
        launch(16'd2);
        tick();
        expected_bytes = 16'd5;   // start while busy must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        expected_bytes = 16'd0;
        for (int n = 0; n < 100 && nib_log.size() < 4; n++) tick();
        repeat (5) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        for (int n = 0; n < 50 && done_cnt == base_done; n++) tick();
        repeat (3) tick();
        exp_q = '{4'h8, 4'hA, 4'h0, 4'h0};
        checks++;
        if (nib_log.size() != 4) begin
            fails++;
            $display("FAIL nominal_nib_count: got %0d want 4", nib_log.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (nib_log[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL nominal_nib[%0d]: got %h want %h", i, nib_log[i], exp_q[i]);
            end
        end
        checks++;
        if (cs_cnt - base_cs != 1) begin
            fails++;
            $display("FAIL nominal_core_start: got %0d pulses want 1", cs_cnt - base_cs);
        end
        checks++;
        if (done_cnt - base_done != 1 || last_err !== 2'd0) begin
            fails++;
            $display("FAIL nominal_done: got %0d pulses err=%0d want 1 pulse err=0", done_cnt - base_done, last_err);
        end
        checks++;
        if (rd_log.size() != 2 || rd_log[0] !== 4'd0 || rd_log[1] !== 4'd1) begin
            fails++;
            $display("FAIL nominal_reads: got %0d reads want addrs 0,1", rd_log.size());
        end
    endtask

    task automatic test_zero_length();
        int base_cs;
        clear_logs();
        base_cs = cs_cnt;
        launch(16'd0);
        checks++;
        if (seq_done !== 1'b0 || seq_err !== 2'd1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL zero_finish: got done=%b err=%0d busy=%b want 0,1,1", seq_done, seq_err, busy);
        end
        tick();
        checks++;
        if (seq_done !== 1'b1 || seq_err !== 2'd1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_done: got done=%b err=%0d busy=%b want 1,1,0", seq_done, seq_err, busy);
        end
        tick();
        checks++;
        if (seq_done !== 1'b0 || seq_err !== 2'd1) begin
            fails++;
            $display("FAIL zero_after: got done=%b err=%0d want 0,1", seq_done, seq_err);
        end
        checks++;
        if (cs_cnt != base_cs || rd_log.size() != 0) begin
            fails++;
            $display("FAIL zero_no_activity: got core_start=%0d reads=%0d want 0,0", cs_cnt - base_cs, rd_log.size());
        end
    endtask

    task automatic test_backpressure();
        int base_done;
        clear_logs();
        mem[0] = 8'h3C;
        mem[1] = 8'hD5;
        mem[2] = 8'h7E;
        rd_lat = 3;
        ready_mode = 1;
        stall_viol = 0;
        stalls = 0;
        base_done = done_cnt;
        launch(16'd3);
        for (int n = 0; n < 200 && nib_log.size() < 6; n++) tick();
        ready_mode = 0;
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        for (int n = 0; n < 50 && done_cnt == base_done; n++) tick();
        exp_q = '{4'h3, 4'hC, 4'hD, 4'h5, 4'h7, 4'hE};
        exp_a = '{4'd0, 4'd1, 4'd2};
        checks++;
        if (nib_log.size() != 6) begin
            fails++;
            $display("FAIL bp_nib_count: got %0d want 6", nib_log.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (nib_log[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL bp_nib[%0d]: got %h want %h", i, nib_log[i], exp_q[i]);
            end
        end
        checks++;
        if (rd_log.size() != 3) begin
            fails++;
            $display("FAIL bp_read_count: got %0d want 3", rd_log.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_log[i] !== exp_a[i]) begin
                fails++;
                $display("FAIL bp_read[%0d]: got %h want %h", i, rd_log[i], exp_a[i]);
            end
        end
        checks++;
        if (stall_viol != 0 || stalls == 0) begin
            fails++;
            $display("FAIL bp_stable: got %0d unstable stalls of %0d want 0 of >0", stall_viol, stalls);
        end
        checks++;
        if (done_cnt - base_done != 1 || last_err !== 2'd0) begin
            fails++;
            $display("FAIL bp_done: got %0d pulses err=%0d want 1, 0", done_cnt - base_done, last_err);
        end
        rd_lat = 1;
    endtask

    task automatic test_timeout();
        int base_done;
        clear_logs();
        mem[0] = 8'h5F;
        base_done = done_cnt;
        launch(16'd1);
        for (int n = 0; n < 60 && done_cnt == base_done; n++) tick();
        checks++;
        if (done_cnt - base_done != 1 || last_err !== 2'd3) begin
            fails++;
            $display("FAIL timeout_err: got %0d pulses err=%0d want 1, 3", done_cnt - base_done, last_err);
        end
        // WAIT_DONE is first visible on the sample after the last nibble
        checks++;
        if (done_cyc - (last_nib_cyc + 1) != 17) begin
            fails++;
            $display("FAIL timeout_latency: got %0d cycles want 17", done_cyc - (last_nib_cyc + 1));
        end
        checks++;
        if (nib_log.size() != 2 || nib_log[0] !== 4'h5 || nib_log[1] !== 4'hF) begin
            fails++;
            $display("FAIL timeout_nibs: got %0d nibbles want 5,F", nib_log.size());
        end
    endtask

    task automatic test_early_done();
        int base_done;
        clear_logs();
        mem[0] = 8'h12;
        mem[1] = 8'h34;
        mem[2] = 8'h56;
        mem[3] = 8'h78;
        base_done = done_cnt;
        launch(16'd4);
        for (int n = 0; n < 50 && nib_log.size() < 2; n++) tick();
        for (int n = 0; n < 50 && rd_log.size() < 2; n++) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        checks++;
        if (busy !== 1'b1 || seq_err !== 2'd2) begin
            fails++;
            $display("FAIL early_finish: got busy=%b err=%0d want 1, 2", busy, seq_err);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || seq_done !== 1'b1) begin
            fails++;
            $display("FAIL early_idle: got busy=%b done=%b want 0, 1", busy, seq_done);
        end
        repeat (4) tick();
        checks++;
        if (rd_log.size() != 2 || nib_log.size() != 2) begin
            fails++;
            $display("FAIL early_abandon: got reads=%0d nibbles=%0d want 2, 2", rd_log.size(), nib_log.size());
        end
        checks++;
        if (done_cnt - base_done != 1 || last_err !== 2'd2) begin
            fails++;
            $display("FAIL early_done_pulse: got %0d pulses err=%0d want 1, 2", done_cnt - base_done, last_err);
        end
    endtask

    task automatic test_reset_mid_run();
        int base_done;
        clear_logs();
        mem[0] = 8'hA5;
        mem[1] = 8'h3C;
        launch(16'd2);
        for (int n = 0; n < 50 && fsm_state !== 3'd5; n++) tick();
        checks++;
        if (fsm_state !== 3'd5) begin
            fails++;
            $display("FAIL rst_reach_send_lo: got state %0d want 5", fsm_state);
        end
        base_done = done_cnt;
        reset = 1'b1;
        start = 1'b1;
        expected_bytes = 16'd1;
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0 || fsm_state !== 3'd0) begin
            fails++;
            $display("FAIL rst_abort: got busy=%b state=%0d want 0, 0", busy, fsm_state);
        end
        reset = 1'b0;
        start = 1'b0;
        expected_bytes = 16'd0;
        repeat (3) tick();
        checks++;
        if (done_cnt != base_done || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_no_done: got %0d pulses busy=%b want 0, 0", done_cnt - base_done, busy);
        end
        clear_logs();
        mem[0] = 8'hC3;
        launch(16'd1);
        for (int n = 0; n < 50 && nib_log.size() < 2; n++) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        for (int n = 0; n < 50 && done_cnt == base_done; n++) tick();
        checks++;
        if (rd_log.size() != 1 || rd_log[0] !== 4'd0) begin
            fails++;
            $display("FAIL rst_restart_addr: got %0d reads first=%h want 1 read at 0", rd_log.size(), rd_log[0]);
        end
        checks++;
        if (nib_log.size() != 2 || nib_log[0] !== 4'hC || nib_log[1] !== 4'h3 || last_err !== 2'd0) begin
            fails++;
            $display("FAIL rst_restart_run: got %0d nibbles err=%0d want C,3 err 0", nib_log.size(), last_err);
        end
    endtask

    task automatic test_addr_wrap();
        int base_done;
        clear_logs();
        for (int i = 0; i < 16; i++) mem[i] = {i[3:0], ~i[3:0]};
        for (int j = 0; j < 17; j++) begin
            exp_a.push_back(j[3:0]);
            exp_q.push_back(j[3:0]);
            exp_q.push_back(~j[3:0]);
        end
        base_done = done_cnt;
        launch(16'd17);
        for (int n = 0; n < 200 && nib_log.size() < 34; n++) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        for (int n = 0; n < 50 && done_cnt == base_done; n++) tick();
        checks++;
        if (rd_log.size() != 17 || nib_log.size() != 34) begin
            fails++;
            $display("FAIL wrap_counts: got reads=%0d nibbles=%0d want 17, 34", rd_log.size(), nib_log.size());
        end
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (rd_log[i] !== exp_a[i] || nib_log[2*i] !== exp_q[2*i] || nib_log[2*i+1] !== exp_q[2*i+1]) begin
                fails++;
                $display("FAIL wrap_byte[%0d]: got addr=%h nib=%h%h want addr=%h nib=%h%h",
                         i, rd_log[i], nib_log[2*i], nib_log[2*i+1], exp_a[i], exp_q[2*i], exp_q[2*i+1]);
            end
        end
        checks++;
        if (last_err !== 2'd0) begin
            fails++;
            $display("FAIL wrap_err: got %0d want 0", last_err);
        end
    endtask

    task automatic test_back_to_back();
        int base_done;
        base_done = done_cnt;
        expected_bytes = 16'd0;
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        repeat (3) tick();
        checks++;
        if (done_cnt - base_done != 2) begin
            fails++;
            $display("FAIL b2b_done_pulses: got %0d want 2", done_cnt - base_done);
        end
    endtask

    task automatic test_idle_done();
        int base_done;
        base_done = done_cnt;
        core_done = 1'b1;
        repeat (2) tick();
        core_done = 1'b0;
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0 || done_cnt != base_done || seq_err !== 2'd1) begin
            fails++;
            $display("FAIL idle_done_ignored: got busy=%b pulses=%0d err=%0d want 0, 0, 1",
                     busy, done_cnt - base_done, seq_err);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_zero_length();
        test_backpressure();
        test_timeout();
        test_early_done();
        test_reset_mid_run();
        test_addr_wrap();
        test_back_to_back();
        test_idle_done();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule

// File: doc/bits_seq.md
BITS_SEQ -- requirements
Module: bits_seq

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096: maximum cycles allowed in WAIT_DONE before an error is flagged.
REQ-002 Parameter AW, default 16: width of the byte-memory address.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse requesting a decode run.
REQ-006 expected_bytes  input  16  number of packet bytes to stream; sampled when start is accepted.
REQ-007 mem_rd  output  1  byte-memory read strobe, one cycle per byte.
REQ-008 mem_addr  output  AW  byte address, valid while mem_rd=1.
REQ-009 mem_rvalid  input  1  read data valid; arrives 1 or more cycles after mem_rd.
REQ-010 mem_rdata  input  8  read byte, valid while mem_rvalid=1.
REQ-011 core_start  output  1  one-cycle pulse that starts the BITS core.
REQ-012 nib_valid  output  1  nibble offered to the core.
REQ-013 nib_data  output  4  nibble value; high nibble of each byte first.
REQ-014 nib_ready  input  1  core accepts a nibble when nib_valid and nib_ready are both 1.
REQ-015 core_done  input  1  core has finished decoding.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 seq_done  output  1  one-cycle pulse at the end of every run, successful or not.
REQ-018 seq_err  output  2  error code, held until the next accepted start: 0 = none, 1 = zero length, 2 = early core_done, 3 = timeout.

Function
REQ-019 States SHALL be: IDLE, LAUNCH, FETCH, WAIT_DATA, SEND_HI, SEND_LO, WAIT_DONE, FINISH.
REQ-020 In IDLE, start=1 with expected_bytes!=0 SHALL do all of the following, then go to LAUNCH:
- latch expected_bytes into a remaining-byte counter;
- clear the address counter to 0;
- clear seq_err.
REQ-021 In IDLE, start=1 with expected_bytes==0 SHALL set seq_err=1, go to FINISH, and issue no core_start.
REQ-022 start SHALL be ignored in every state other than IDLE.
REQ-023 LAUNCH SHALL assert core_start for exactly one cycle, then go to FETCH.
REQ-024 FETCH SHALL assert mem_rd for exactly one cycle with mem_addr equal to the address counter, then go to WAIT_DATA.
REQ-025 In WAIT_DATA, mem_rvalid=1 SHALL capture mem_rdata into a byte register and go to SEND_HI; mem_rvalid in any other state SHALL be ignored.
REQ-026 SEND_HI SHALL drive nib_valid=1 with nib_data=byte[7:4]; on handshake, go to SEND_LO.
REQ-027 SEND_LO SHALL drive nib_valid=1 with nib_data=byte[3:0]. On handshake it SHALL:
- increment the address counter;
- decrement the remaining counter;
- go to FETCH if remaining was greater than 1, otherwise to WAIT_DONE.
REQ-028 nib_valid and nib_data SHALL remain stable until the handshake completes; nib_valid=0 outside SEND_HI and SEND_LO.
REQ-029 Minimum throughput SHALL be one byte per 4 cycles: FETCH, WAIT_DATA (mem_rvalid=1 on the first cycle), SEND_HI, SEND_LO, each with nib_ready=1.
REQ-030 The address counter SHALL wrap modulo 2^AW without error.
REQ-031 core_done=1 in any of FETCH, WAIT_DATA, SEND_HI or SEND_LO SHALL set seq_err=2 and go to FINISH, abandoning the remaining bytes.
REQ-032 In WAIT_DONE, core_done=1 SHALL go to FINISH with seq_err=0.
REQ-033 The timeout counter SHALL clear on entry to WAIT_DONE and increment every cycle in WAIT_DONE.
REQ-034 If the timeout counter reaches TIMEOUT_CYCLES-1 in WAIT_DONE without core_done, the block SHALL set seq_err=3 and go to FINISH; core_done in that same cycle takes priority and yields seq_err=0.
REQ-035 FINISH SHALL assert seq_done for one cycle, then go to IDLE.
REQ-036 In FINISH, start SHALL be ignored; a new run is possible from the following cycle.
REQ-037 core_done in IDLE, LAUNCH or FINISH SHALL be ignored.
REQ-038 All outputs SHALL be registered or decoded from state only, with no combinational path from any input to any output.

Reset
REQ-039 While reset=1, on each rising clk edge the block SHALL:
- enter IDLE;
- clear the address, remaining, timeout and byte registers;
- drive busy, seq_done, core_start, mem_rd and nib_valid to 0;
- drive mem_addr=0, nib_data=0, seq_err=0.
REQ-040 Reset asserted mid-run SHALL abort the run with no seq_done pulse; start is ignored while reset=1.

Verification
REQ-041 Nominal run: expected_bytes=2, memory holds 8A 00, nib_ready=1, core_done 5 cycles after the 4th nibble -> the bench SHALL see:
- core_start once;
- nibbles 8, A, 0, 0 in order;
- seq_done pulse with seq_err=0.
REQ-042 Zero length: start with expected_bytes=0 -> seq_done one cycle after FINISH entry, seq_err=1, no core_start, no mem_rd.
REQ-043 Backpressure: nib_ready toggled 0/1 every cycle with mem_rvalid delayed 3 cycles -> nib_data stable while stalled, all 2N nibbles delivered, mem_addr values 0..N-1 each read exactly once.
REQ-044 Timeout: TIMEOUT_CYCLES=16, core_done never asserted -> seq_err=3, and seq_done arrives 17 cycles after WAIT_DONE entry.
REQ-045 Early done: core_done asserted after the 1st byte of a 4-byte run -> seq_err=2, no further mem_rd, busy=0 two cycles later.
REQ-046 Reset during SEND_LO followed by a new start -> the new run begins at mem_addr=0, and no seq_done pulse is produced for the aborted run.
